// File: rtl/aes192_rkey_store.sv
// Round-key store for the AES-192 datapath: captures RK0 from the cipher key
// plus the 12 expanded subkeys, then serves them through a registered random
// read port and an ascending/descending ready/valid stream.
module aes192_rkey_store #(
  parameter int NRK = 13,
  parameter int KW  = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [191:0]  short_key,
  input  logic [KW-1:0] subkey,
  input  logic          valid_skey,
  output logic          keys_ready,
  input  logic [3:0]    rd_addr,
  output logic [KW-1:0] rd_data,
  input  logic          stream_start,
  input  logic          stream_dir,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [KW-1:0] rk_data,
  output logic [3:0]    rk_idx,
  output logic          rk_last,
  output logic          ovf
);

  typedef enum logic [1:0] {EMPTY, CAPTURE, READY, STREAM} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NRK - 1);

  state_t        state_q, state_d;
  logic [3:0]    cap_cnt_q, cap_cnt_d;
  logic [KW-1:0] mem_q [NRK];
  logic [KW-1:0] mem_d [NRK];
  logic          keys_ready_q, keys_ready_d;
  logic [KW-1:0] rd_data_q, rd_data_d;
  logic          rk_valid_q, rk_valid_d;
  logic [KW-1:0] rk_data_q, rk_data_d;
  logic [3:0]    rk_idx_q, rk_idx_d;
  logic          rk_last_q, rk_last_d;
  logic          ovf_q, ovf_d;
  logic          dir_q, dir_d;
  logic [3:0]    nxt_idx;

  // The low 64 key bits only feed the expander; RK0 is the upper 128 bits.
  logic unused_key_lo;
  assign unused_key_lo = ^short_key[63:0];

  // Next-state logic: load has top priority and aborts capture or stream.
  always_comb begin
    state_d      = state_q;
    cap_cnt_d    = cap_cnt_q;
    mem_d        = mem_q;
    keys_ready_d = keys_ready_q;
    rk_valid_d   = rk_valid_q;
    rk_data_d    = rk_data_q;
    rk_idx_d     = rk_idx_q;
    rk_last_d    = rk_last_q;
    ovf_d        = ovf_q;
    dir_d        = dir_q;
    nxt_idx      = rk_idx_q;
    rd_data_d    = '0;

    if (keys_ready_q && (rd_addr <= LAST_IDX)) begin
      rd_data_d = mem_q[rd_addr];
    end

    if (start) begin
      mem_d[0]     = short_key[191 -: KW];
      cap_cnt_d    = 4'd1;
      keys_ready_d = 1'b0;
      rk_valid_d   = 1'b0;
      rk_last_d    = 1'b0;
      ovf_d        = 1'b0;
      state_d      = CAPTURE;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (valid_skey && (cap_cnt_q <= LAST_IDX)) begin
            mem_d[cap_cnt_q] = subkey;
            cap_cnt_d        = cap_cnt_q + 4'd1;
            if (cap_cnt_q == LAST_IDX) begin
              keys_ready_d = 1'b1;
              state_d      = READY;
            end
          end
        end
        READY: begin
          if (valid_skey) begin
            ovf_d = 1'b1;
          end
          if (stream_start) begin
            nxt_idx    = stream_dir ? LAST_IDX : 4'd0;
            dir_d      = stream_dir;
            rk_valid_d = 1'b1;
            rk_idx_d   = nxt_idx;
            rk_data_d  = mem_q[nxt_idx];
            rk_last_d  = 1'b0;
            state_d    = STREAM;
          end
        end
        STREAM: begin
          if (valid_skey) begin
            ovf_d = 1'b1;
          end
          if (rk_valid_q && rk_ready) begin
            if (rk_last_q) begin
              rk_valid_d = 1'b0;
              rk_last_d  = 1'b0;
              state_d    = READY;
            end else begin
              nxt_idx   = dir_q ? (rk_idx_q - 4'd1) : (rk_idx_q + 4'd1);
              rk_idx_d  = nxt_idx;
              rk_data_d = mem_q[nxt_idx];
              rk_last_d = dir_q ? (nxt_idx == 4'd0) : (nxt_idx == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, key array and registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      cap_cnt_q    <= '0;
      for (int i = 0; i < NRK; i++) begin
        mem_q[i] <= '0;
      end
      keys_ready_q <= 1'b0;
      rd_data_q    <= '0;
      rk_valid_q   <= 1'b0;
      rk_data_q    <= '0;
      rk_idx_q     <= '0;
      rk_last_q    <= 1'b0;
      ovf_q        <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_cnt_q    <= cap_cnt_d;
      mem_q        <= mem_d;
      keys_ready_q <= keys_ready_d;
      rd_data_q    <= rd_data_d;
      rk_valid_q   <= rk_valid_d;
      rk_data_q    <= rk_data_d;
      rk_idx_q     <= rk_idx_d;
      rk_last_q    <= rk_last_d;
      ovf_q        <= ovf_d;
      dir_q        <= dir_d;
    end
  end

  assign keys_ready = keys_ready_q;
  assign rd_data    = rd_data_q;
  assign rk_valid   = rk_valid_q;
  assign rk_data    = rk_data_q;
  assign rk_idx     = rk_idx_q;
  assign rk_last    = rk_last_q;
  assign ovf        = ovf_q;

endmodule

// File: doc/aes192_rkey_store.md
# aes192_rkey_store

Round-key store for the AES-192 datapath. It sits directly downstream of the AES-192 key expander and captures round key 0 (taken from the cipher key itself) plus the 12 expanded subkeys the expander streams out. Once all 13 round keys are held, it serves them two ways: a random-access read port, and a sequenced stream to the round engine. The stream runs in ascending order for encryption and descending order for decryption, with ready/valid backpressure.

## Interface
Parameters
- NRK, 13, number of round keys held (fixed for AES-192; indices 0..12).
- KW, 128, round-key width in bits.

Ports
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  load pulse; driven by the same signal as the expander's start.
- short_key  in  192  cipher key; sampled only when start=1.
- subkey  in  128  subkey from the expander.
- valid_skey  in  1  expander subkey-valid qualifier.
- keys_ready  out  1  all 13 round keys captured.
- rd_addr  in  4  random-read index.
- rd_data  out  128  random-read data, registered.
- stream_start  in  1  request a full round-key stream.
- stream_dir  in  1  0 = encrypt (indices 0→12), 1 = decrypt (indices 12→0); sampled with stream_start.
- rk_valid  out  1  stream beat valid.
- rk_ready  in  1  consumer accepts the beat.
- rk_data  out  128  stream round key.
- rk_idx  out  4  index of the current stream beat.
- rk_last  out  1  final beat of the stream.
- ovf  out  1  sticky flag: a subkey beat arrived when no slot was open.

## Operation
- Storage: 13×128 register array `mem`; write counter `cap_cnt` [3:0]; state machine with states EMPTY, CAPTURE, READY, STREAM.
- Load has the highest priority after reset and is accepted in any state. On start=1:
  - mem[0] ← short_key[191:64]; cap_cnt ← 1.
  - keys_ready ← 0, rk_valid ← 0, ovf ← 0.
  - state ← CAPTURE. Any stream in progress is aborted.
- CAPTURE:
  - Each cycle with valid_skey=1: mem[cap_cnt] ← subkey, cap_cnt ← cap_cnt+1.
  - Gaps in valid_skey are tolerated; the block waits in CAPTURE.
  - The write to index 12 moves the state to READY and sets keys_ready=1 on the same edge.
- valid_skey=1 in READY or STREAM sets ovf=1 and leaves mem unchanged. In EMPTY, valid_skey is ignored and ovf stays 0.
- READY:
  - stream_start=1 latches stream_dir and loads the stream pointer with 0 (dir=0) or 12 (dir=1).
  - state ← STREAM.
  - stream_start in any other state is ignored.
- STREAM:
  - Outputs rk_valid=1, rk_data=mem[ptr], rk_idx=ptr, rk_last=1 when ptr is 12 (dir=0) or 0 (dir=1).
  - On rk_valid & rk_ready: ptr steps by ±1. When the accepted beat has rk_last=1: rk_valid ← 0 and state ← READY.
  - While rk_ready=0, rk_data, rk_idx and rk_last hold stable.
- Random read: rd_data ← mem[rd_addr] every cycle when keys_ready=1. rd_data ← 0 when keys_ready=0 or rd_addr>12.
- Reset: state EMPTY, cap_cnt 0, mem cleared. keys_ready, rd_data, rk_valid, rk_data, rk_idx, rk_last and ovf are all 0.

## Timing
- Load timeline: start sampled at edge t. Expander subkeys RK1..RK12 arrive at edges t+1..t+12 (back-to-back). keys_ready=1 after edge t+12.
- rd_data latency: 1 cycle from rd_addr.
- Stream latency: rk_valid rises 1 cycle after stream_start is sampled. With rk_ready held high, 13 beats occupy 13 consecutive cycles and the block returns to READY on the edge of the last beat. A new stream_start is accepted the cycle after that.
- Stream outputs are registered; there is no combinational path from rk_ready to rk_data.
- start during STREAM: rk_valid drops on the next edge, with no rk_last beat.
- reset during CAPTURE or STREAM: all outputs are 0 on the next edge.
- start and valid_skey in the same cycle: start wins and the beat is discarded.

## Test plan
- Load key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b through the expander -> keys_ready=1 exactly 12 cycles after start. rd_addr=0 returns 8e73b0f7da0e6452c810f32b809079e5, rd_addr=1 returns 62f8ead2522c6b7bfe0c91f72402f5a5, rd_addr=12 returns e98ba06f448c773c8ecc720401002202. ovf=0.
- Encrypt stream with rk_ready=1 -> 13 consecutive beats with rk_idx 0..12, rk_last only on idx 12, then READY.
- Decrypt stream with rk_ready toggling 1,0,1,0… -> beats idx 12..0. Data holds while rk_ready=0. Total 25 cycles from first beat to last accept.
- Subkeys injected manually with 3-cycle gaps -> capture is correct and keys_ready asserts only after the 12th beat. An extra 13th beat sets ovf=1, and rd_addr=12 is unchanged.
- start asserted mid-stream (at beat idx 5) -> rk_valid=0 next cycle, keys_ready=0, and recapture completes with the new key.
- reset at cycle 6 of capture -> all outputs 0, keys_ready stays 0, and rd_data=0 for every address.
